// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: command opcodes, access lengths,
// FSM state encoding and small command-decoding helpers.
package mem_stage_pkg;

    localparam int DEF_CMD_W  = 6;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Access length codes presented to the memory controller
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    // Command opcodes carried on cmdtype
    localparam logic [DEF_CMD_W-1:0] CMD_NOP  = 6'd0;
    localparam logic [DEF_CMD_W-1:0] CMD_ADDI = 6'd1;
    localparam logic [DEF_CMD_W-1:0] CMD_ADD  = 6'd2;
    localparam logic [DEF_CMD_W-1:0] CMD_LB   = 6'd8;
    localparam logic [DEF_CMD_W-1:0] CMD_LH   = 6'd9;
    localparam logic [DEF_CMD_W-1:0] CMD_LW   = 6'd10;
    localparam logic [DEF_CMD_W-1:0] CMD_LBU  = 6'd11;
    localparam logic [DEF_CMD_W-1:0] CMD_LHU  = 6'd12;
    localparam logic [DEF_CMD_W-1:0] CMD_SB   = 6'd16;
    localparam logic [DEF_CMD_W-1:0] CMD_SH   = 6'd17;
    localparam logic [DEF_CMD_W-1:0] CMD_SW   = 6'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [DEF_CMD_W-1:0] cmd);
        return (cmd == CMD_LB) || (cmd == CMD_LH) || (cmd == CMD_LW) ||
               (cmd == CMD_LBU) || (cmd == CMD_LHU);
    endfunction

    function automatic logic is_store(input logic [DEF_CMD_W-1:0] cmd);
        return (cmd == CMD_SB) || (cmd == CMD_SH) || (cmd == CMD_SW);
    endfunction

    function automatic logic [1:0] cmd_len(input logic [DEF_CMD_W-1:0] cmd);
        logic [1:0] len;
        case (cmd)
            CMD_LB, CMD_LBU, CMD_SB: len = LEN_BYTE;
            CMD_LH, CMD_LHU, CMD_SH: len = LEN_HALF;
            default:                 len = LEN_WORD;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data extension: picks the byte/half/word out of the raw read data and
// sign- or zero-extends it according to the load command.
module load_extend
    import mem_stage_pkg::*;
#(
    parameter int CMD_W  = DEF_CMD_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [CMD_W-1:0]  cmdtype_i,
    input  logic [DATA_W-1:0] raw_i,
    output logic [DATA_W-1:0] ext_o
);

    // Select and extend the loaded field; words pass through untouched
    always_comb begin
        ext_o = raw_i;
        case (cmdtype_i)
            CMD_LB:  ext_o = {{(DATA_W-8){raw_i[7]}}, raw_i[7:0]};
            CMD_LBU: ext_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
            CMD_LH:  ext_o = {{(DATA_W-16){raw_i[15]}}, raw_i[15:0]};
            CMD_LHU: ext_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. Non-memory ops pass straight through; loads and stores
// run a req/done handshake with the memory controller while the stage holds
// the upstream pipeline via stall_req_o. Results are forwarded to ID.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CMD_W  = DEF_CMD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [CMD_W-1:0]  cmdtype_in,
    input  logic [4:0]        rsd_addr_in,
    input  logic [DATA_W-1:0] rsd_data_in,
    input  logic              write_rsd_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [1:0]        mem_len_o,
    input  logic              mem_done_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [4:0]        rsd_addr_o,
    output logic [DATA_W-1:0] rsd_data_o,
    output logic              write_rsd_o,
    output logic              mem_forward_o,
    output logic [4:0]        mem_forward_addr_o,
    output logic [DATA_W-1:0] mem_forward_data_o,
    output logic              stall_req_o
);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        len_q, len_d;
    logic [DATA_W-1:0] ldbuf_q, ldbuf_d;
    logic [DATA_W-1:0] ext_data;
    logic              load_op;
    logic              mem_op;

    assign load_op = is_load(cmdtype_in);
    assign mem_op  = load_op | is_store(cmdtype_in);

    // cmdtype_in is held by the stalled EX_MEM latch, so it still names the
    // load when the done pulse arrives.
    load_extend #(
        .CMD_W  (CMD_W),
        .DATA_W (DATA_W)
    ) u_load_extend (
        .cmdtype_i (cmdtype_in),
        .raw_i     (mem_rdata_i),
        .ext_o     (ext_data)
    );

    // Next-state logic: issue in IDLE, wait for done, one DONE cycle to retire
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        ldbuf_d = ldbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = ~load_op;
                    addr_d  = mem_addr_in;
                    wdata_d = store_data_in;
                    len_d   = cmd_len(cmdtype_in);
                end
            end
            ST_WAIT: begin
                if (mem_done_i) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    ldbuf_d = ext_data;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and access registers; everything freezes while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= 2'd0;
            ldbuf_q <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            ldbuf_q <= ldbuf_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_len_o   = len_q;

    // Releasing the stall in DONE lets EX_MEM advance, so the op is never reissued
    assign stall_req_o = mem_op && (state_q != ST_DONE);

    // Writeback: pass-through for ALU ops, buffered load data only in DONE
    always_comb begin
        rsd_addr_o  = rsd_addr_in;
        rsd_data_o  = rsd_data_in;
        write_rsd_o = write_rsd_in;
        if (mem_op) begin
            rsd_data_o  = ldbuf_q;
            write_rsd_o = load_op && (state_q == ST_DONE) && write_rsd_in;
        end
    end

    assign mem_forward_o      = write_rsd_o && (rsd_addr_o != 5'd0);
    assign mem_forward_addr_o = mem_forward_o ? rsd_addr_o : 5'd0;
    assign mem_forward_data_o = mem_forward_o ? rsd_data_o : '0;

endmodule
